// File: rtl/crc32_pkg.sv
// Shared CRC-32 definitions: reflected byte-update function, standard constants,
// rx-check FSM states and the per-frame result payload.
package crc32_pkg;

    localparam int unsigned CRC_W  = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [CRC_W-1:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [CRC_W-1:0] CRC32_INIT_STD  = 32'hFFFFFFFF;
    localparam logic [CRC_W-1:0] CRC32_XOR_STD   = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_t;

    typedef struct packed {
        logic             crc_ok;
        logic             err_short;
        logic [CRC_W-1:0] crc_calc;
        logic [CRC_W-1:0] crc_rx;
    } crc_result_t;

    // One byte through the reflected CRC-32 (poly 0x04C11DB7), LSB first.
    function automatic logic [CRC_W-1:0] crc32_byte_next(input logic [CRC_W-1:0] c,
                                                         input logic [BYTE_W-1:0] d);
        logic [CRC_W-1:0] r;
        r = c ^ CRC_W'(d);
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC32_POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_rx_check.sv
// Receive-side CRC-32 frame checker: a 4-byte delay line keeps the trailing FCS
// out of the running CRC, then the CRC is compared against the delayed bytes.
module crc32_rx_check
    import crc32_pkg::*;
#(
    parameter logic [CRC_W-1:0] INIT      = CRC32_INIT_STD,
    parameter logic [CRC_W-1:0] FINAL_XOR = CRC32_XOR_STD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              done,
    output logic              crc_ok,
    output logic              err_short,
    output logic [CRC_W-1:0]  crc_calc,
    output logic [CRC_W-1:0]  crc_rx
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(4);

    state_t                        state, state_n;
    logic [CRC_W-1:0]              crc_reg, crc_n;
    logic [CNT_W-1:0]              cnt, cnt_n;
    logic [3:0][BYTE_W-1:0]        sr, sr_n;
    crc_result_t                   res, res_n;
    logic                          ready_n, done_n;

    logic                          xfer;
    logic [CRC_W-1:0]              crc_upd;
    logic [CRC_W-1:0]              crc_fin;
    logic [CRC_W-1:0]              rx_word;

    // Next-state, datapath and output decode.
    always_comb begin
        state_n = state;
        crc_n   = crc_reg;
        cnt_n   = cnt;
        sr_n    = sr;
        res_n   = res;
        ready_n = 1'b0;
        done_n  = 1'b0;

        xfer    = in_valid && in_ready;
        crc_upd = crc32_byte_next(crc_reg, sr[0]);
        crc_fin = ((cnt == CNT_SAT) ? crc_upd : crc_reg) ^ FINAL_XOR;
        // Shifted delay line; its 32-bit view is also the received FCS word.
        rx_word = {in_data, sr[3], sr[2], sr[1]};

        case (state)
            IDLE: begin
                state_n = ACCUM;
                ready_n = 1'b1;
            end
            ACCUM: begin
                ready_n = 1'b1;
                if (xfer) begin
                    if (cnt == CNT_SAT) begin
                        crc_n = crc_upd;
                    end
                    sr_n  = rx_word;
                    cnt_n = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
                    if (in_last) begin
                        res_n.crc_calc  = crc_fin;
                        res_n.crc_rx    = rx_word;
                        res_n.err_short = (cnt < CNT_W'(3));
                        res_n.crc_ok    = (cnt >= CNT_W'(3)) && (crc_fin == rx_word);
                        state_n         = REPORT;
                        ready_n         = 1'b0;
                        done_n          = 1'b1;
                    end
                end
            end
            REPORT: begin
                crc_n   = INIT;
                cnt_n   = '0;
                sr_n    = '0;
                state_n = ACCUM;
                ready_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            crc_reg  <= INIT;
            cnt      <= '0;
            sr       <= '0;
            res      <= '0;
            in_ready <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            crc_reg  <= crc_n;
            cnt      <= cnt_n;
            sr       <= sr_n;
            res      <= res_n;
            in_ready <= ready_n;
            done     <= done_n;
        end
    end

    assign crc_ok    = res.crc_ok;
    assign err_short = res.err_short;
    assign crc_calc  = res.crc_calc;
    assign crc_rx    = res.crc_rx;

endmodule

// File: tb/tb_crc32_rx_check.sv
// Bench for crc32_rx_check: two instances (zero INIT/XOR and standard) share one
// byte stream; a frame-level reference model predicts every reported result.
module tb_crc32_rx_check;
    import crc32_pkg::*;

    typedef logic [7:0] bytes_t [$];

    typedef struct {
        int          due;
        logic [31:0] calc0;
        logic [31:0] calc1;
        logic [31:0] rx;
        logic        ok0;
        logic        ok1;
        logic        short_f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;

    logic        rdy0, done0, ok0, short0;
    logic [31:0] calc0, rx0;
    logic        rdy1, done1, ok1, short1;
    logic [31:0] calc1, rx1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        prev_done = 1'b0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc32_rx_check #(.INIT(32'h0), .FINAL_XOR(32'h0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .done(done0), .crc_ok(ok0),
        .err_short(short0), .crc_calc(calc0), .crc_rx(rx0)
    );

    crc32_rx_check u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .done(done1), .crc_ok(ok1),
        .err_short(short1), .crc_calc(calc1), .crc_rx(rx1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference: CRC over all but the last four bytes, FCS = last four
    // bytes little-endian (zero-padded when the frame is short).
    function automatic exp_t model(input bytes_t fr);
        exp_t        e;
        logic [31:0] c0, c1;
        int          n;
        n  = fr.size();
        c0 = 32'h0;
        c1 = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            c0 = crc32_byte_next(c0, fr[i]);
            c1 = crc32_byte_next(c1, fr[i]);
        end
        e.rx = 32'h0;
        for (int k = 0; k < 4 && k < n; k++) begin
            e.rx = e.rx | (32'(fr[n-1-k]) << (8 * (3 - k)));
        end
        e.calc0   = c0;
        e.calc1   = c1 ^ 32'hFFFFFFFF;
        e.short_f = (n < 4);
        e.ok0     = !e.short_f && (e.calc0 == e.rx);
        e.ok1     = !e.short_f && (e.calc1 == e.rx);
        e.due     = 0;
        return e;
    endfunction

    // Result monitor: done must appear exactly one cycle after each last-byte transfer.
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("done0", 32'(done0), 32'd1);
            check_eq("done1", 32'(done1), 32'd1);
            check_eq("ready_in_report", 32'(rdy1), 32'd0);
            check_eq("crc_calc0", calc0, e.calc0);
            check_eq("crc_calc1", calc1, e.calc1);
            check_eq("crc_rx0", rx0, e.rx);
            check_eq("crc_rx1", rx1, e.rx);
            check_eq("err_short0", 32'(short0), 32'(e.short_f));
            check_eq("err_short1", 32'(short1), 32'(e.short_f));
            check_eq("crc_ok0", 32'(ok0), 32'(e.ok0));
            check_eq("crc_ok1", 32'(ok1), 32'(e.ok1));
        end else if (done0 || done1) begin
            check_eq("spurious_done", 32'(done0 | done1), 32'd0);
        end
        if (prev_done && rst_n) begin
            check_eq("ready_after_report", 32'(rdy0 & rdy1), 32'd1);
        end
        prev_done = done1;
    end

    task automatic send_frame(input bytes_t fr, input int gap_pct, input bit mark_last);
        int i = 0;
        int stall = 0;
        while (i < fr.size()) begin
            @(negedge clk);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = fr[i];
                in_last  = mark_last && (i == fr.size() - 1);
                if (rdy1) begin
                    if (in_last) begin
                        exp_t e;
                        e     = model(fr);
                        e.due = cyc + 1;
                        exp_q.push_back(e);
                    end
                    i++;
                    stall = 0;
                end else begin
                    stall++;
                    if (stall > 50) begin
                        check_eq("ready_timeout", 32'd0, 32'd1);
                        in_valid = 1'b0;
                        return;
                    end
                end
            end
        end
    endtask

    task automatic wait_drain();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'({rdy0, rdy1}), 32'd0);
        check_eq({tag, "_done"}, 32'({done0, done1}), 32'd0);
        check_eq({tag, "_flags"}, 32'({ok0, ok1, short0, short1}), 32'd0);
        check_eq({tag, "_calc"}, calc0 | calc1, 32'd0);
        check_eq({tag, "_rx"}, rx0 | rx1, 32'd0);
    endtask

    function automatic bytes_t rand_frame();
        bytes_t      fr;
        logic [31:0] c;
        int          len;
        if ($urandom_range(9) == 0) begin
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
            return fr;
        end
        len = $urandom_range(0, 10);
        c   = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            fr.push_back(8'($urandom));
            c = crc32_byte_next(c, fr[i]);
        end
        c = c ^ 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) fr.push_back(8'(c >> (8 * k)));
        if ($urandom_range(3) == 0) begin
            int p;
            p     = $urandom_range(0, fr.size() - 1);
            fr[p] = fr[p] ^ 8'(1 << $urandom_range(0, 7));
        end
        return fr;
    endfunction

    initial begin
        bytes_t fr;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        fr = '{8'h01, 8'h96, 8'h30, 8'h07, 8'h77};
        send_frame(fr, 0, 1'b1);
        wait_drain();
        check_eq("tp1_calc", calc0, 32'h77073096);
        check_eq("tp1_rx", rx0, 32'h77073096);
        check_eq("tp1_ok", 32'(ok0), 32'd1);

        fr = '{8'h01, 8'h96, 8'h31, 8'h07, 8'h77};
        send_frame(fr, 0, 1'b1);
        wait_drain();
        check_eq("tp2_ok", 32'(ok0), 32'd0);
        check_eq("tp2_rx", rx0, 32'h77073196);
        check_eq("tp2_short", 32'(short0), 32'd0);

        fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 0, 1'b1);
        wait_drain();
        check_eq("tp3_calc", calc0, 32'h0);
        check_eq("tp3_ok", 32'(ok0), 32'd1);

        // Short frame immediately followed by a valid standard frame.
        fr = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(fr, 0, 1'b1);
        @(negedge clk);
        check_eq("tp4_short", 32'(short1), 32'd1);
        check_eq("tp4_ok", 32'(ok1), 32'd0);
        fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(fr, 0, 1'b1);
        wait_drain();
        check_eq("tp4_next_ok", 32'(ok1), 32'd1);

        // Back-to-back frames with in_valid held high, then with random gaps.
        for (int f = 0; f < 40; f++) send_frame(rand_frame(), 0, 1'b1);
        wait_drain();
        for (int f = 0; f < 40; f++) send_frame(rand_frame(), 30, 1'b1);
        wait_drain();

        // Reset mid-frame after three bytes: no done, outputs cleared.
        fr = '{8'h11, 8'h22, 8'h33};
        send_frame(fr, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midreset_nodone", 32'({done0, done1}), 32'd0);

        fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(fr, 20, 1'b1);
        wait_drain();
        check_eq("tp6_calc", calc1, 32'hCBF43926);
        check_eq("tp6_ok", 32'(ok1), 32'd1);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc32_rx_check.md
Name: crc32_rx_check

Overview:
- Receive-side CRC-32 frame checker; the counterpart to the team's combinational CRC-32 byte-update logic used on the transmit side.
- Consumes a byte stream framed by `in_last`. The final 4 bytes of each frame are the received FCS.
- Runs the payload bytes through the same byte-update equations and compares the result with the received FCS.
- Reports pass/fail per frame to the link-layer controller.

Parameters:
- `INIT`, 32'hFFFFFFFF, CRC register value at the start of each frame.
- `FINAL_XOR`, 32'hFFFFFFFF, XOR applied to the accumulated CRC before comparison.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  byte present on `in_data`.
- `in_ready`  out  1  checker can accept a byte this cycle.
- `in_data`  in  8  stream byte.
- `in_last`  in  1  marks the final byte of the frame (last FCS byte).
- `done`  out  1  one-cycle pulse: frame result valid.
- `crc_ok`  out  1  `crc_calc == crc_rx`, and the frame is not short.
- `err_short`  out  1  frame had fewer than 4 bytes.
- `crc_calc`  out  32  computed CRC after `FINAL_XOR`.
- `crc_rx`  out  32  received FCS; first FCS byte is in `[7:0]`.

Behaviour:
- Reset (`rst_n`=0 at an edge):
  - state=IDLE, `crc_reg`=`INIT`, `cnt`=0, `sr[0..3]`=0.
  - Outputs: `in_ready`=0, `done`=0, `crc_ok`=0, `err_short`=0, `crc_calc`=0, `crc_rx`=0.
  - Reset wins over any simultaneous input and aborts any frame in progress; no `done` is issued for it.
- `f(c,d)` is the team CRC-32 byte-update function, reflected, poly 0x04C11DB7. Sanity value: `f(0,8'h01)`=32'h77073096.
- A transfer happens when `in_valid && in_ready`.
- States:
  - IDLE: the cycle after reset, `in_ready`=1; go to ACCUM.
  - ACCUM: `in_ready`=1. On each transfer of byte b:
    - if `cnt`>=4: `crc_reg`<=`f(crc_reg, sr[0])`.
    - Always: `sr`<={`sr[1]`,`sr[2]`,`sr[3]`,b}; `cnt`<=`cnt`+1, saturating at 4.
    - The 4-byte delay line means the FCS bytes never enter the CRC.
  - ACCUM on a transfer with `in_last`=1, with p = (`cnt`>=4 ? `f(crc_reg,sr[0])` : `crc_reg`):
    - `crc_calc`<=p ^ `FINAL_XOR`.
    - `crc_rx`<={b,`sr[3]`,`sr[2]`,`sr[1]`}.
    - `err_short`<=(`cnt`<3).
    - `crc_ok`<=!`err_short` && match.
    - Go to REPORT.
  - REPORT (exactly 1 cycle): `done`=1, `in_ready`=0. Reset `crc_reg`=`INIT`, `cnt`=0, `sr`=0. Go to ACCUM.
- Result outputs hold their values until the next REPORT; they are only meaningful while `done`=1.
- Minimum frame is 4 bytes (empty payload, `crc_calc`=`INIT`^`FINAL_XOR`).
- Latency: `done` is asserted the cycle after the `in_last` transfer.
- Throughput: 1 byte/cycle, plus 1 bubble per frame.
- `in_valid` low stalls with no state change.
- Frames have no length limit; `cnt` saturates.
- `in_last` on the first byte of a frame is legal and gives `err_short`=1.

Decomposition:
- Package `crc32_pkg`:
  - function `crc32_byte_next(logic [31:0] c, logic [7:0] d)` implementing f.
  - constants `CRC32_INIT_STD` and `CRC32_XOR_STD`.
  - state enum {IDLE, ACCUM, REPORT}.
- No sub-module. The function is shared with the transmit-side generator, and the bench uses it as the golden model.

Test Plan:
- `INIT`=0, `FINAL_XOR`=0. Stream 01,96,30,07,77 (last on 77) -> `done` 1 cycle later, `crc_calc`=32'h77073096, `crc_rx`=32'h77073096, `crc_ok`=1.
- Same frame with FCS byte 30 changed to 31 -> `crc_ok`=0, `crc_rx`=32'h77073196, `err_short`=0.
- `INIT`=0, `FINAL_XOR`=0. 8 zero bytes, last on the 8th -> `crc_calc`=0, `crc_ok`=1.
- 3-byte frame AA,BB,CC (last on CC) -> `err_short`=1, `crc_ok`=0. The next valid frame must still pass.
- Back-to-back frames with `in_valid` held high -> `in_ready`=0 exactly in the REPORT cycle, no byte lost. Insert random `in_valid` gaps -> results unchanged.
- Default params, reset pulsed mid-frame after 3 bytes -> no `done`, outputs 0. A following full frame with standard FCS ("123456789" + 26,39,F4,CB) -> `crc_calc`=32'hCBF43926, `crc_ok`=1.
